uno_draw_scheduler: RTL and testbench

Arbitrates draw requests from four player seats and sequences the shared card deck so that only one multi-card draw runs at a time. A granted seat's 1/2/4-card draw is issued to the deck and held until every card has been seen. Each drawn card is forwarded to the game logic tagged with the owning seat. The block sits between the per-seat turn logic and the deck block.

---
 rtl/uno_draw_scheduler.sv | 177 +++++++++++++++++
 tb/tb_uno_draw_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uno_draw_scheduler.sv
// Round-robin arbiter that grants one seat at a time a 1/2/4-card draw on the shared deck,
// forwards each drawn card tagged with its seat, and aborts a draw when the deck goes silent.
module uno_draw_scheduler #(
  parameter int N_SEAT  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_SEAT-1:0]     i_req,
  input  logic [3*N_SEAT-1:0]   i_req_cnt,
  output logic [N_SEAT-1:0]     o_grant,
  output logic                  o_busy,
  output logic [2:0]            o_deck_draw,
  input  logic                  i_deck_done,
  input  logic                  i_deck_drawn,
  input  logic [5:0]            i_deck_card,
  output logic                  o_card_valid,
  output logic [5:0]            o_card,
  output logic [1:0]            o_card_seat,
  output logic                  o_xfer_done,
  output logic                  o_abort,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] TMO      = 8'(TIMEOUT);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [1:0]         rr_q, rr_d;
  logic [1:0]         seat_q, seat_d;
  logic [2:0]         rem_q, rem_d;
  logic [7:0]         timer_q, timer_d;
  logic               aborted_q, aborted_d;
  logic [N_SEAT-1:0]  grant_d;
  logic               busy_d, card_valid_d, xfer_d, abort_d;
  logic [2:0]         draw_d;
  logic [5:0]         card_d;
  logic [1:0]         card_seat_d;
  logic [N_SEAT-1:0]  elig;
  logic               pick_valid;
  logic [1:0]         pick, idx;
  logic [2:0]         pick_cnt;

  function automatic logic onehot3(input logic [2:0] c);
    return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
  endfunction

  assign o_state = state_q;

  always_comb begin
    elig = '0;
    for (int k = 0; k < N_SEAT; k++) elig[k] = i_req[k] & onehot3(i_req_cnt[3*k +: 3]);
  end

  // Scan from farthest to nearest so the seat closest after rr_q wins.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    idx        = '0;
    pick_cnt   = '0;
    for (int i = N_SEAT; i >= 1; i--) begin
      idx = rr_q + 2'(i);
      if (elig[idx]) begin
        pick_valid = 1'b1;
        pick       = idx;
      end
    end
    for (int k = 0; k < N_SEAT; k++) begin
      if (pick == 2'(k)) pick_cnt = i_req_cnt[3*k +: 3];
    end
  end

  // Deck handshake: o_deck_draw is held nonzero while cards are owed; every cycle
  // with i_deck_drawn high in ISSUE transfers exactly one card; i_deck_done high means
  // the deck is ready to accept a new draw (IDLE) or has finished (RELEASE).
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    seat_d       = seat_q;
    rem_d        = rem_q;
    timer_d      = timer_q;
    aborted_d    = aborted_q;
    grant_d      = '0;
    busy_d       = o_busy;
    draw_d       = o_deck_draw;
    card_valid_d = 1'b0;
    card_d       = o_card;
    card_seat_d  = o_card_seat;
    xfer_d       = 1'b0;
    abort_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_deck_done && pick_valid) begin
          grant_d   = N_SEAT'(1) << pick;
          busy_d    = 1'b1;
          seat_d    = pick;
          rem_d     = pick_cnt;  // one-hot code 001/010/100 equals the card count
          draw_d    = pick_cnt;
          timer_d   = '0;
          aborted_d = 1'b0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_deck_drawn) begin
          card_valid_d = 1'b1;
          card_d       = i_deck_card;
          card_seat_d  = seat_q;
          rem_d        = rem_q - 3'd1;
          timer_d      = '0;
          if (rem_q == 3'd1) begin
            draw_d  = '0;
            state_d = S_RELEASE;
          end
        end else if (timer_q != TMO) begin
          timer_d = timer_q + 8'd1;
          if (timer_q == TMO_LAST) begin
            draw_d    = '0;
            abort_d   = 1'b1;
            aborted_d = 1'b1;
            state_d   = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        if (i_deck_done) begin
          xfer_d  = ~aborted_q;
          busy_d  = 1'b0;
          rr_d    = seat_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      rr_q         <= 2'd3;
      seat_q       <= '0;
      rem_q        <= '0;
      timer_q      <= '0;
      aborted_q    <= 1'b0;
      o_grant      <= '0;
      o_busy       <= 1'b0;
      o_deck_draw  <= '0;
      o_card_valid <= 1'b0;
      o_card       <= '0;
      o_card_seat  <= '0;
      o_xfer_done  <= 1'b0;
      o_abort      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      seat_q       <= seat_d;
      rem_q        <= rem_d;
      timer_q      <= timer_d;
      aborted_q    <= aborted_d;
      o_grant      <= grant_d;
      o_busy       <= busy_d;
      o_deck_draw  <= draw_d;
      o_card_valid <= card_valid_d;
      o_card       <= card_d;
      o_card_seat  <= card_seat_d;
      o_xfer_done  <= xfer_d;
      o_abort      <= abort_d;
    end
  end

endmodule

// File: tb/tb_uno_draw_scheduler.sv
// Bench for uno_draw_scheduler: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uno_draw_scheduler;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [11:0] req_cnt = '0;
  logic        deck_done = 1'b1;
  logic        deck_drawn = 1'b0;
  logic [5:0]  deck_card = '0;
  logic [3:0]  grant;
  logic        busy;
  logic [2:0]  deck_draw;
  logic        card_valid;
  logic [5:0]  card;
  logic [1:0]  card_seat;
  logic        xfer_done;
  logic        abort_p;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  uno_draw_scheduler #(.N_SEAT(4), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_cnt(req_cnt),
    .o_grant(grant), .o_busy(busy), .o_deck_draw(deck_draw),
    .i_deck_done(deck_done), .i_deck_drawn(deck_drawn), .i_deck_card(deck_card),
    .o_card_valid(card_valid), .o_card(card), .o_card_seat(card_seat),
    .o_xfer_done(xfer_done), .o_abort(abort_p), .o_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  bit lit_en = 1'b0;
  int grant_log[$];
  int xfer_cnt = 0;
  int abort_cnt = 0;
  int card_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit         m_active = 1'b0;
  bit         m_aborted = 1'b0;
  int         m_seat = 0, m_left = 0, m_silent = 0, m_last = 3, m_pick = 0;
  logic [3:0] e_grant = '0;
  logic       e_busy = 1'b0, e_cv = 1'b0, e_xfer = 1'b0, e_abort = 1'b0;
  logic [2:0] e_draw = '0;
  logic [5:0] e_card = '0;
  logic [1:0] e_seat = '0;

  function automatic logic [2:0] field_of(input int s);
    logic [11:0] c;
    c = req_cnt;
    return c[3*s +: 3];
  endfunction

  function automatic bit seat_ok(input int s);
    return req[s] && ($countones(field_of(s)) == 1);
  endfunction

  function automatic int n_cards(input logic [2:0] f);
    case (f)
      3'b001:  return 1;
      3'b010:  return 2;
      default: return 4;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_aborted = 1'b0; m_seat = 0; m_left = 0; m_silent = 0; m_last = 3;
      e_grant = '0; e_busy = 1'b0; e_draw = '0; e_cv = 1'b0; e_card = '0; e_seat = '0;
      e_xfer = 1'b0; e_abort = 1'b0;
    end else begin
      e_grant = '0; e_cv = 1'b0; e_xfer = 1'b0; e_abort = 1'b0;
      if (!m_active) begin
        if (deck_done) begin
          for (int i = 1; i <= 4; i++) begin
            m_pick = (m_last + i) % 4;
            if (!m_active && seat_ok(m_pick)) begin
              m_active = 1'b1; m_aborted = 1'b0; m_seat = m_pick; m_silent = 0;
              m_left = n_cards(field_of(m_pick));
              e_grant = 4'(1 << m_pick); e_busy = 1'b1; e_draw = field_of(m_pick);
            end
          end
        end
      end else if (m_left > 0 && !m_aborted) begin
        if (deck_drawn) begin
          e_cv = 1'b1; e_card = deck_card; e_seat = 2'(m_seat);
          m_left--; m_silent = 0;
          if (m_left == 0) e_draw = '0;
        end else begin
          m_silent++;
          if (m_silent >= TIMEOUT) begin
            m_aborted = 1'b1; e_abort = 1'b1; e_draw = '0;
          end
        end
      end else if (deck_done) begin
        e_xfer = !m_aborted; e_busy = 1'b0; m_last = m_seat; m_active = 1'b0;
      end
    end
  end

  // ---------------- compare process / scoreboard ----------------
  always @(negedge clk) begin
    chk("grant", grant, e_grant);
    chk("busy", busy, e_busy);
    chk("deck_draw", deck_draw, e_draw);
    chk("card_valid", card_valid, e_cv);
    chk("card", card, e_card);
    chk("card_seat", card_seat, e_seat);
    chk("xfer_done", xfer_done, e_xfer);
    chk("abort", abort_p, e_abort);
    for (int k = 0; k < 4; k++) if (grant[k]) grant_log.push_back(k);
    if (xfer_done) xfer_cnt++;
    if (abort_p) abort_cnt++;
    if (card_valid) begin
      card_cnt++;
      if (lit_en) begin
        chk("lit_card_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("lit_card", {card_seat, card}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req = '0; req_cnt = '0; deck_drawn = 1'b0; deck_done = 1'b1;
    lit_en = 1'b0; exp_q.delete();
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_grant(input logic [3:0] expg, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == '0 && n < 50);
    chk(name, grant, expg);
  endtask

  task automatic deck_pulse(input logic [5:0] c);
    deck_drawn = 1'b1;
    deck_card  = c;
    @(negedge clk);
    deck_drawn = 1'b0;
  endtask

  task automatic deck_step();
    deck_done  = 1'b1;
    deck_drawn = (deck_draw != 3'b000) ? 1'($urandom_range(0, 1)) : 1'b0;
    deck_card  = 6'($urandom);
  endtask

  task automatic drain(input string name);
    int n = 0;
    req = '0;
    while (busy && n < 200) begin
      @(negedge clk);
      deck_step();
      n++;
    end
    deck_drawn = 1'b0;
    chk(name, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, c0, a0, n, ng, s0, s3, g0;
    logic [5:0] t2_cards[4];
    logic [2:0] f;
    t2_cards = '{6'h01, 6'h13, 6'h3C, 6'h0E};

    // reset state
    tick(2);
    chk("rst_grant", grant, 0); chk("rst_busy", busy, 0); chk("rst_draw", deck_draw, 0);
    chk("rst_cv", card_valid, 0); chk("rst_xfer", xfer_done, 0); chk("rst_abort", abort_p, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    tick(1);

    // seat 2, single card
    req = 4'b0100; req_cnt = 12'b000_001_000_000; deck_done = 1'b1;
    wait_grant(4'b0100, "t1_grant");
    chk("t1_draw", deck_draw, 3'b001); chk("t1_busy", busy, 1);
    req = '0; req_cnt = '0; deck_done = 1'b0;
    lit_en = 1'b1; exp_q.push_back({2'd2, 6'h2A});
    tick(2);
    deck_pulse(6'h2A);
    chk("t1_cv", card_valid, 1); chk("t1_draw_off", deck_draw, 0);
    tick(3);
    chk("t1_busy_hold", busy, 1);
    x0 = xfer_cnt;
    deck_done = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!xfer_done && n < 20);
    chk("t1_xfer", xfer_done, 1);
    tick(3);
    chk("t1_xfer_once", xfer_cnt - x0, 1); chk("t1_q_empty", exp_q.size(), 0);

    // seat 1, draw four on spaced pulses
    req = 4'b0010; req_cnt = 12'b000_000_100_000;
    wait_grant(4'b0010, "t2_grant");
    chk("t2_draw", deck_draw, 3'b100);
    req = '0;
    c0 = card_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back({2'd1, t2_cards[i]});
    for (int i = 0; i < 4; i++) begin
      tick(1 + (i % 2) + 1);
      chk("t2_draw_held", deck_draw, 3'b100);
      deck_pulse(t2_cards[i]);
      chk("t2_cv", card_valid, 1);
      chk("t2_draw_after", deck_draw, (i == 3) ? 3'b000 : 3'b100);
    end
    tick(3);
    chk("t2_cards", card_cnt - c0, 4); chk("t2_busy_end", busy, 0); chk("t2_q_empty", exp_q.size(), 0);
    lit_en = 1'b0;

    // all four seats, round robin
    apply_reset();
    req = 4'b1111; req_cnt = 12'b010_010_010_010;
    g0 = grant_log.size(); x0 = xfer_cnt; ng = 0; n = 0;
    while (ng < 5 && n < 400) begin
      @(negedge clk); n++;
      if (grant != '0) ng++;
      deck_step();
    end
    @(negedge clk); deck_step();
    chk("t3_grants", ng, 5);
    chk("t3_xfers_between", xfer_cnt - x0, 4);
    if (grant_log.size() >= g0 + 5)
      for (int i = 0; i < 5; i++) chk("t3_order", grant_log[g0 + i], i % 4);
    drain("t3_drain");

    // malformed count on seat 0 is masked
    req = 4'b1001; req_cnt = 12'b010_000_000_011;
    s0 = 0; s3 = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (grant[0]) s0++;
      if (grant[3]) s3++;
      deck_step();
    end
    chk("t4_seat0_never", s0, 0); chk("t4_seat3_served", s3 >= 2, 1);
    drain("t4_drain");

    // timeout after one card of a draw-two
    apply_reset();
    req = 4'b0100; req_cnt = 12'b000_010_000_000;
    wait_grant(4'b0100, "t5_grant");
    req = '0;
    tick(1);
    x0 = xfer_cnt;
    deck_pulse(6'h15);
    chk("t5_cv", card_valid, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!abort_p && n < 400);
    chk("t5_abort_cycles", n, TIMEOUT); chk("t5_draw_off", deck_draw, 0);
    tick(5);
    chk("t5_no_xfer", xfer_cnt - x0, 0); chk("t5_busy_end", busy, 0);

    // asynchronous reset mid draw-four
    req = 4'b0010; req_cnt = 12'b000_000_100_000;
    wait_grant(4'b0010, "t6_grant");
    req = '0; lit_en = 1'b1; exp_q.push_back({2'd1, 6'h07});
    tick(1);
    deck_pulse(6'h07);
    chk("t6_cv", card_valid, 1);
    tick(1);
    @(posedge clk); #2; rst_n = 1'b0; #1;
    chk("t6_async_busy", busy, 0); chk("t6_async_draw", deck_draw, 0);
    chk("t6_async_card", card, 0); chk("t6_async_seat", card_seat, 0);
    chk("t6_async_grant", grant, 0); chk("t6_async_abort", abort_p, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); deck_drawn = 1'b1; deck_card = 6'h3F;
      @(negedge clk); chk("t6_no_cv_in_reset", card_valid, 0);
    end
    deck_drawn = 1'b0; rst_n = 1'b1;
    tick(2);
    chk("t6_idle_busy", busy, 0); chk("t6_no_cv", card_valid, 0); chk("t6_q_empty", exp_q.size(), 0);
    lit_en = 1'b0;
    req = 4'b0011; req_cnt = 12'b000_000_001_001;
    wait_grant(4'b0001, "t6_seat0_first");
    drain("t6_drain");

    // randomized traffic with periodic deck silence
    apply_reset();
    x0 = xfer_cnt; a0 = abort_cnt;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        req = 4'($urandom);
        for (int k = 0; k < 4; k++) begin
          case ($urandom_range(0, 5))
            0: f = 3'b001; 1: f = 3'b010; 2: f = 3'b100;
            3: f = 3'b000; 4: f = 3'b011; default: f = 3'b111;
          endcase
          req_cnt[3*k +: 3] = f;
        end
      end
      deck_done  = ($urandom_range(0, 3) != 0);
      deck_drawn = ((cyc % 1500) >= 700 && (cyc % 1500) < 1000) ? 1'b0 : ($urandom_range(0, 2) == 0);
      deck_card  = 6'($urandom);
    end
    drain("rand_drain");
    tick(2);
    chk("rand_saw_xfer", (xfer_cnt - x0) > 20, 1);
    chk("rand_saw_abort", (abort_cnt - a0) > 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
